// File: rtl/data_memory.sv
// data_memory: 512 x 32 word-addressed data memory for the load/store stage.
// One combinational read port and one unconditional synchronous write port.
// An asynchronous active-low reset clears every word to zero. Callers that
// are not storing park the write port at address 0 with data 0, so word 0
// is a scratch location.
module data_memory #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9,
  parameter int DEPTH      = 512
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] readAddress,
  output logic [DATA_WIDTH-1:0] readData,
  input  logic [ADDR_WIDTH-1:0] writeAddress,
  input  logic [DATA_WIDTH-1:0] writeData
);

  // Storage array; each entry is one data word.
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Read data taken straight from the array, with no bypass of the write port.
  logic [DATA_WIDTH-1:0] w_read_data;

  // Clear every word while in reset; otherwise store writeData on every edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      r_mem[writeAddress] <= writeData;
    end
  end

  // Combinational read: the output follows readAddress within the cycle.
  always_comb begin
    w_read_data = r_mem[readAddress];
  end

  assign readData = w_read_data;

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against an
// array-based reference model of the memory contents.
module tb_data_memory;

  localparam int DW    = 32;
  localparam int AW    = 9;
  localparam int DEPTH = 512;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] readAddress;
  logic [DW-1:0] readData;
  logic [AW-1:0] writeAddress;
  logic [DW-1:0] writeData;

  int n_pass;
  int n_total;
  bit cmp_en;

  // Reference model: the memory contents as a plain array.
  logic [DW-1:0] model [DEPTH];

  data_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dmem (
    .clk          (clk),
    .rst_n        (rst_n),
    .readAddress  (readAddress),
    .readData     (readData),
    .writeAddress (writeAddress),
    .writeData    (writeData)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: a write lands on each rising edge outside reset.
  always @(posedge clk) begin
    if (rst_n) model[writeAddress] = writeData;
  end

  // Model: reset wipes everything immediately.
  always @(negedge rst_n) begin
    for (int i = 0; i < DEPTH; i++) model[i] = 32'd0;
  end

  task automatic check(input string name, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
  endtask

  // Compare the read port against the model in the middle of every cycle.
  always @(negedge clk) begin
    if (cmp_en) check("model_read", readData, model[readAddress]);
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic park();
    writeAddress = 9'd0;
    writeData    = 32'd0;
  endtask

  task automatic read_chk(input string name, input logic [AW-1:0] a,
                          input logic [DW-1:0] exp);
    readAddress = a;
    #1;
    check(name, readData, exp);
  endtask

  initial begin
    n_pass = 0; n_total = 0; cmp_en = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = 32'd0;
    rst_n = 1'b0; readAddress = 9'd0;
    park();

    // 1. Reset clear.
    tick(); tick();
    read_chk("rst_a0",   9'd0,   32'd0);
    read_chk("rst_a10",  9'd10,  32'd0);
    read_chk("rst_a11",  9'd11,  32'd0);
    read_chk("rst_a511", 9'd511, 32'd0);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // 2. Two writes, then park.
    writeAddress = 9'd10; writeData = 32'd12345; tick();
    writeAddress = 9'd11; writeData = 32'd6789;  tick();
    park();
    // 3. Combinational read between edges.
    read_chk("wr_a10", 9'd10, 32'd12345);
    read_chk("wr_a11", 9'd11, 32'd6789);
    check("model_pin_10", model[10], 32'd12345);

    // 4. Same-address read/write: old before the edge, new after it.
    writeAddress = 9'd20; writeData = 32'hDEADBEEF;
    read_chk("rw_before", 9'd20, 32'd0);
    tick();
    read_chk("rw_after", 9'd20, 32'hDEADBEEF);
    park();

    // 5. Asynchronous mid-run reset.
    read_chk("pre_rst_a10", 9'd10, 32'd12345);
    rst_n = 1'b0;
    read_chk("async_a10", 9'd10, 32'd0);
    read_chk("async_a11", 9'd11, 32'd0);
    writeAddress = 9'd12; writeData = 32'd5;
    tick();
    read_chk("rst_wr_a12", 9'd12, 32'd0);
    park();
    rst_n = 1'b1;
    tick();

    // 6. Boundary addresses and scratch word 0.
    writeAddress = 9'd511; writeData = 32'hFFFFFFFF; tick();
    writeAddress = 9'd1;   writeData = 32'd1;        tick();
    writeAddress = 9'd0;   writeData = 32'hA5A50001; tick();
    park();
    read_chk("bnd_a511", 9'd511, 32'hFFFFFFFF);
    read_chk("bnd_a1",   9'd1,   32'd1);
    read_chk("bnd_a0",   9'd0,   32'hA5A50001);
    tick();
    read_chk("park_a0",  9'd0,   32'd0);
    check("model_pin_511", model[511], 32'hFFFFFFFF);

    // Randomized traffic; addresses often drawn from a small window so
    // reads hit recently written words.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        park();
      end else begin
        writeAddress = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 15))
                                                   : AW'($urandom);
        writeData    = $urandom;
      end
      readAddress = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 15))
                                                : AW'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        #1;
        check("rand_async_rst", readData, 32'd0);
      end else begin
        rst_n = 1'b1;
      end
      tick();
    end
    rst_n = 1'b1;
    tick();
    cmp_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
